// File: rtl/pio_in_edge_irq.sv
// Input PIO: synchronised, optionally debounced pins with sticky
// edge capture and a maskable interrupt on a 4-word slave port.
module pio_in_edge_irq #(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter int               EDGE_TYPE       = 0,
    parameter int               IRQ_TYPE        = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev_filtered;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] irq_src;
    logic [31:0]      rd_mux;
    logic             wr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= RESET_VALUE;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filtered = s;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] filt_q;

            // Counter tracks consecutive cycles the pin disagrees with filt_q
            always_ff @(posedge clk) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (!reset_n) begin
                        cnt[i]    <= '0;
                        filt_q[i] <= RESET_VALUE[i];
                    end else if (s[i] == filt_q[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == LAST) begin
                        filt_q[i] <= s[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end

            assign filtered = filt_q;
        end
    endgenerate

    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            0:       edge_hit = filtered & ~prev_filtered;
            1:       edge_hit = ~filtered & prev_filtered;
            default: edge_hit = filtered ^ prev_filtered;
        endcase
    end

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

    assign irq_src = (IRQ_TYPE == 1) ? (edgecapture & irqmask)
                                     : (filtered & irqmask);

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = filtered;
            2'd1:    rd_mux[WIDTH-1:0] = irqmask;
            2'd2:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_filtered <= RESET_VALUE;
            irqmask       <= '0;
            edgecapture   <= '0;
            readdata      <= '0;
            irq           <= 1'b0;
        end else begin
            prev_filtered <= filtered;
            if (wr && address == 2'd1)
                irqmask <= writedata[WIDTH-1:0];
            // A set in the same cycle as its clear wins
            edgecapture <= (edgecapture & ~clr) | edge_hit;
            readdata    <= rd_mux;
            irq         <= |irq_src;
        end
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: an undebounced rising-edge instance and a
// debounced any-edge level-irq instance against a behavioural model.
module tb_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        write_n;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
        .EDGE_TYPE(0), .IRQ_TYPE(1), .RESET_VALUE(8'h00)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(cs), .write_n(write_n), .writedata(writedata),
        .readdata(rd_a), .in_port(in_port), .irq(irq_a)
    );

    pio_in_edge_irq #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(2), .IRQ_TYPE(0), .RESET_VALUE(8'h00)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(cs), .write_n(write_n), .writedata(writedata),
        .readdata(rd_b), .in_port(in_port), .irq(irq_b)
    );

    // Reference state: pins is the pin history seen through the synchroniser
    logic [7:0]  pins [$];
    logic [7:0]  mf    [2];
    logic [7:0]  mp    [2];
    logic [7:0]  mec   [2];
    logic [7:0]  mmask [2];
    logic        mirq  [2];
    logic [31:0] mrd   [2];
    int          mrun  [2][8];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pins = {8'h00, 8'h00};
        for (int k = 0; k < 2; k++) begin
            mf[k] = 0; mp[k] = 0; mec[k] = 0; mmask[k] = 0;
            mirq[k] = 0; mrd[k] = 0;
            for (int i = 0; i < 8; i++) mrun[k][i] = 0;
        end
    endtask

    task automatic step();
        logic [7:0]  s, f, e, clr, pin_now;
        logic [7:0]  nf [2];
        logic [7:0]  np [2];
        logic [7:0]  nec [2];
        logic [7:0]  nmask [2];
        logic        nirq [2];
        logic [31:0] nrd [2];
        logic        rst, wr;
        rst     = !reset_n;
        wr      = cs && !write_n;
        pin_now = in_port;
        s       = pins[0];
        clr     = (wr && address == 2) ? writedata[7:0] : 8'h00;
        for (int k = 0; k < 2; k++) begin
            f = (k == 0) ? s : mf[k];
            if (k == 0) e = f & ~mp[k];
            else        e = f ^ mp[k];
            nec[k]   = (mec[k] & ~clr) | e;
            nmask[k] = (wr && address == 1) ? writedata[7:0] : mmask[k];
            nirq[k]  = (k == 0) ? |(mec[k] & mmask[k]) : |(f & mmask[k]);
            case (address)
                2'd0:    nrd[k] = {24'h0, f};
                2'd1:    nrd[k] = {24'h0, mmask[k]};
                2'd2:    nrd[k] = {24'h0, mec[k]};
                default: nrd[k] = 32'h0;
            endcase
            np[k] = f;
            nf[k] = mf[k];
            if (k == 1) begin
                for (int i = 0; i < 8; i++) begin
                    if (s[i] != mf[k][i]) begin
                        mrun[k][i]++;
                        if (mrun[k][i] == 4) begin
                            nf[k][i]   = s[i];
                            mrun[k][i] = 0;
                        end
                    end else begin
                        mrun[k][i] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                mf[k] = nf[k]; mp[k] = np[k]; mec[k] = nec[k];
                mmask[k] = nmask[k]; mirq[k] = nirq[k]; mrd[k] = nrd[k];
            end
            pins.push_back(pin_now);
            void'(pins.pop_front());
        end
        #1;
        chk("rd_a", rd_a, mrd[0]);
        chk("irq_a", {31'h0, irq_a}, {31'h0, mirq[0]});
        chk("rd_b", rd_b, mrd[1]);
        chk("irq_b", {31'h0, irq_b}, {31'h0, mirq[1]});
    endtask

    task automatic bus_wr(logic [1:0] a, logic [31:0] d);
        cs = 1; write_n = 0; address = a; writedata = d;
        step();
        cs = 0; write_n = 1;
    endtask

    initial begin
        int hold;
        reset_n = 0; cs = 0; write_n = 1; address = 0;
        writedata = 0; in_port = 8'hFF;
        model_reset();
        repeat (3) step();
        chk("rst_rd", rd_a, 32'h0);
        chk("rst_irq", {31'h0, irq_a}, 32'h0);

        reset_n = 1;
        repeat (3) step();
        chk("data_ff", rd_a, 32'hFF);
        address = 2;
        step();
        chk("ec_ff", rd_a, 32'hFF);
        bus_wr(2, 32'hFF);
        step();
        chk("ec_clr", rd_a, 32'h0);

        in_port = 8'h00;
        repeat (8) step();
        bus_wr(1, 32'h04);
        bus_wr(2, 32'hFF);
        address = 2;
        in_port = 8'h04;
        repeat (4) step();
        chk("ec_bit2", rd_a, 32'h04);
        chk("irq_set", {31'h0, irq_a}, 32'h1);

        in_port = 8'h00;
        repeat (4) step();
        in_port = 8'h04;
        step();
        step();
        bus_wr(2, 32'h04);
        address = 2;
        step();
        chk("coll_ec", rd_a, 32'h04);
        chk("coll_irq", {31'h0, irq_a}, 32'h1);
        bus_wr(2, 32'h04);
        address = 2;
        step();
        chk("clr_irq", {31'h0, irq_a}, 32'h0);
        chk("clr_ec", rd_a, 32'h0);

        bus_wr(1, 32'hFFFF_FFFF);
        address = 1;
        step();
        chk("mask_w", rd_a, 32'hFF);
        bus_wr(0, 32'h5A5A_5A5A);
        bus_wr(3, 32'hFFFF_FFFF);
        address = 3;
        step();
        chk("addr3", rd_a, 32'h0);
        address = 0;
        step();
        chk("data_ro", rd_a, 32'h04);

        in_port = 8'h00;
        repeat (10) step();
        in_port = 8'h01;
        repeat (3) step();
        in_port = 8'h00;
        repeat (10) step();
        chk("db_glitch", rd_b, 32'h0);
        in_port = 8'h01;
        repeat (6) step();
        chk("db_early", rd_b, 32'h0);
        step();
        chk("db_pass", rd_b, 32'h1);
        in_port = 8'h00;
        repeat (10) step();

        hold = 0;
        repeat (3000) begin
            if (hold == 0) begin
                in_port = in_port ^ (8'($urandom) & 8'($urandom));
                hold = $urandom_range(1, 8);
            end
            hold--;
            cs        = ($urandom_range(0, 3) == 0);
            write_n   = 1'($urandom_range(0, 1));
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            reset_n   = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised Avalon-MM input PIO; successor to the single-bit, data-only input port.
- Samples WIDTH asynchronous input pins through a synchroniser and an optional per-channel debounce filter.
- Latches configurable edges into a sticky edge-capture register and raises a maskable interrupt.
- Sits on the system interconnect as a 4-word slave: SD-card detect and write-protect, push-buttons, switches.

Parameters:
- WIDTH, 8: number of input channels, 1..32.
- SYNC_STAGES, 2: synchroniser flops per channel, 2..4.
- DEBOUNCE_CYCLES, 0: stable cycles required before the filtered value changes; 0 bypasses the filter.
- EDGE_TYPE, 0: edges captured; 0 rising, 1 falling, 2 any.
- IRQ_TYPE, 1: 0 level (irq from filtered data), 1 edge (irq from edge capture).
- RESET_VALUE, 0: reset value of synchroniser and filtered data, WIDTH bits.

Ports:
- clk  in  1  system clock; everything in this single clock domain.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous input pins.
- irq  out  1  registered interrupt request, active high.

Behaviour:
- Reset (reset_n low at a rising edge):
  - readdata = 0, irq = 0, irqmask = 0, edgecapture = 0.
  - Synchroniser chain and filtered data = RESET_VALUE; prev_filtered = RESET_VALUE; debounce counters = 0.
  - Reset mid-debounce or mid-capture discards all pending state; no edge is generated by reset release itself.
- Register map, all fields zero-extended to 32 bits:
  - 0 DATA: read-only, filtered data; writes ignored.
  - 1 IRQMASK: read/write, bits [WIDTH-1:0].
  - 2 EDGECAPTURE: read; a write clears every bit whose writedata bit is 1 (write-1-to-clear).
  - 3: reads 0, writes ignored.
- Read path:
  - readdata is updated every clock from the address mux, irrespective of chipselect; 1-cycle latency.
  - Address presented before edge N is valid after edge N.
- Synchroniser: SYNC_STAGES-flop chain per channel, output s.
- Debounce, DEBOUNCE_CYCLES = D > 0:
  - Per-channel counter of width clog2(D+1).
  - If s == filtered: counter <= 0.
  - Else if counter == D-1: filtered <= s and counter <= 0.
  - Else: counter increments.
  - A glitch shorter than D cycles never reaches filtered.
  - D = 0: filtered = s combinationally.
- Edge detect:
  - prev_filtered registered every cycle.
  - rise = filtered & ~prev_filtered; fall = ~filtered & prev_filtered.
  - EDGE_TYPE selects rise, fall or rise|fall.
- Edge capture:
  - edgecapture[i] <= (edgecapture[i] & ~clr[i]) | edge[i].
  - clr is writedata[WIDTH-1:0] when a write hits address 2, else 0.
  - An edge in the same cycle as a clear on that bit: set wins.
- irq:
  - IRQ_TYPE 1: irq <= |(edgecapture & irqmask).
  - IRQ_TYPE 0: irq <= |(filtered & irqmask).
  - irq deasserts one cycle after the clear or mask write.
- Latency, D = 0, in_port changed before edge E0:
  - s changes after edge E0+SYNC_STAGES-1.
  - DATA readdata and edgecapture bit change after E0+SYNC_STAGES.
  - irq after E0+SYNC_STAGES+1.
  - D > 0 adds D edges.
- Unused upper bits: writedata bits above WIDTH are ignored; readdata bits above WIDTH always read 0.

Test Plan:
- Reset: hold reset_n low 3 cycles with in_port=8'hFF, RESET_VALUE=0 -> readdata=0, irq=0; after release, read addr 0 -> 8'hFF after 3 edges; edgecapture reads 8'h01..FF per rising edge (EDGE_TYPE 0).
- Edge + irq: mask=8'h04, in_port[2] 0->1 -> edgecapture=8'h04 at E0+2, irq=1 at E0+3; write addr 2 data 8'h04 -> edgecapture=0, irq=0 one cycle later.
- Set/clear collision: write-1-clear bit 2 in the same cycle edge[2] fires -> edgecapture[2] stays 1, irq stays 1.
- Debounce D=4: 3-cycle pulse on in_port[0] -> DATA and edgecapture unchanged; 6-cycle pulse -> DATA[0]=1 after E0+SYNC_STAGES+4.
- EDGE_TYPE 2, IRQ_TYPE 0: toggle in_port[1] 0->1->0 -> edgecapture[1] set by each edge; irq follows filtered[1] & mask[1], deasserts 1 cycle after the pin-low reaches filtered.
- Map: write 32'hFFFFFFFF to addr 1 with WIDTH=8 -> reads 32'h000000FF; write to addr 0 and 3 -> no effect; addr 3 reads 0.
